// File: rtl/adc_pkg.sv
// adc_pkg: shared frame geometry and FSM state encoding for the ADC sample source.
// No ports; imported by adc_sample_src.
package adc_pkg;
    localparam int FRAME_BITS = 16;
    localparam int LEAD_BITS  = 4;
    localparam int DATA_BITS  = 12;
    typedef enum logic [2:0] {IDLE, CS_SETUP, SHIFT, CS_HOLD, LATCH} state_e;
endpackage

// File: rtl/adc_rate_tick.sv
// adc_rate_tick: free-running 0..DIV-1 counter producing a one-clk tick on the last count.
// Ports: clk (system clock), rst (async active-low reset), tick (high when count == DIV-1).
module adc_rate_tick #(
    parameter int DIV = 2500
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int W = $clog2(DIV);
    logic [W-1:0] cnt_q, cnt_d;
    assign tick  = (cnt_q == W'(DIV - 1));
    assign cnt_d = tick ? '0 : cnt_q + 1'b1;
    always_ff @(posedge clk or negedge rst)
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
endmodule

// File: rtl/adc_sample_src.sv
// adc_sample_src: paces a 16-bit serial ADC read at FS_HZ and presents a held 12-bit signed sample.
// Ports: clk, rst (async active-low), adc_sdo (ADC data in), adc_cs_n / adc_sclk (ADC chip
// select and CPOL=1 serial clock), din (signed sample), pls20k (strobe when din updates),
// lead_err (strobe with pls20k when the frame's 4 leading bits are non-zero).
// Build option: define ADC_OFFSET_BIN_EN when the ADC delivers offset-binary data.
module adc_sample_src
    import adc_pkg::*;
#(
    parameter int CLK_HZ   = 50000000,
    parameter int FS_HZ    = 20000,
    parameter int SCLK_DIV = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        adc_sdo,
    output logic                        adc_cs_n,
    output logic                        adc_sclk,
    output logic signed [DATA_BITS-1:0] din,
    output logic                        pls20k,
    output logic                        lead_err
);
    localparam int FS_DIV = CLK_HZ / FS_HZ;
    localparam logic [5:0] S_LAST = 6'(SCLK_DIV - 1);

    if (SCLK_DIV < 1 || SCLK_DIV > 63) begin : g_bad_sclk
        $error("adc_sample_src: SCLK_DIV must be 1..63");
    end
    if (34 * SCLK_DIV + 2 >= FS_DIV) begin : g_bad_rate
        $error("adc_sample_src: frame does not fit in one sample period");
    end

    state_e                      st_q, st_d;
    logic [5:0]                  div_q, div_d;
    logic [4:0]                  half_q, half_d;
    logic                        cs_n_q, cs_n_d;
    logic                        sclk_q, sclk_d;
    logic [FRAME_BITS-1:0]       sr_q, sr_d;
    logic signed [DATA_BITS-1:0] din_q, din_d;
    logic                        pls_q, pls_d;
    logic                        lead_q, lead_d;
    logic                        tick;
    logic                        div_end;
    logic [DATA_BITS-1:0]        data;

    adc_rate_tick #(.DIV(FS_DIV)) u_rate (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign div_end = (div_q == S_LAST);

`ifdef ADC_OFFSET_BIN_EN
    assign data = {~sr_q[DATA_BITS-1], sr_q[DATA_BITS-2:0]};
`else
    assign data = sr_q[DATA_BITS-1:0];
`endif

    // div_q paces each S-cycle phase; half_q counts the 32 SCLK half-periods (odd = high).
    always_comb begin
        st_d   = st_q;
        div_d  = div_q + 6'd1;
        half_d = half_q;
        cs_n_d = cs_n_q;
        sclk_d = sclk_q;
        sr_d   = sr_q;
        din_d  = din_q;
        pls_d  = 1'b0;
        lead_d = 1'b0;
        case (st_q)
            IDLE: begin
                div_d = '0;
                if (tick) begin
                    st_d   = CS_SETUP;
                    cs_n_d = 1'b0;
                end
            end
            CS_SETUP: if (div_end) begin
                st_d   = SHIFT;
                div_d  = '0;
                half_d = '0;
                sclk_d = 1'b0;
            end
            SHIFT: begin
                // Sample in the first cycle of each high phase; the ADC moved sdo on the prior fall.
                if (sclk_q && div_q == '0) sr_d = {sr_q[FRAME_BITS-2:0], adc_sdo};
                if (div_end) begin
                    div_d = '0;
                    if (half_q == 5'd31) st_d = CS_HOLD;
                    else begin
                        half_d = half_q + 5'd1;
                        sclk_d = ~sclk_q;
                    end
                end
            end
            CS_HOLD: if (div_end) begin
                st_d   = LATCH;
                cs_n_d = 1'b1;
                din_d  = data;
                pls_d  = 1'b1;
                lead_d = |sr_q[FRAME_BITS-1 -: LEAD_BITS];
            end
            LATCH:   st_d = IDLE;
            default: st_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            st_q   <= IDLE;
            div_q  <= '0;
            half_q <= '0;
            cs_n_q <= 1'b1;
            sclk_q <= 1'b1;
            sr_q   <= '0;
            din_q  <= '0;
            pls_q  <= 1'b0;
            lead_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            div_q  <= div_d;
            half_q <= half_d;
            cs_n_q <= cs_n_d;
            sclk_q <= sclk_d;
            sr_q   <= sr_d;
            din_q  <= din_d;
            pls_q  <= pls_d;
            lead_q <= lead_d;
        end

    assign adc_cs_n = cs_n_q;
    assign adc_sclk = sclk_q;
    assign din      = din_q;
    assign pls20k   = pls_q;
    assign lead_err = lead_q;
endmodule

// File: tb/tb_adc_sample_src.sv
// tb_adc_sample_src: scoreboard bench with a serial ADC model and a per-frame protocol checker.
module tb_adc_sample_src;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic adc_sdo = 1'b0;
    logic adc_cs_n, adc_sclk, pls20k, lead_err;
    logic signed [11:0] din;

    always #5 clk = ~clk;

    adc_sample_src dut (
        .clk      (clk),
        .rst      (rst),
        .adc_sdo  (adc_sdo),
        .adc_cs_n (adc_cs_n),
        .adc_sclk (adc_sclk),
        .din      (din),
        .pls20k   (pls20k),
        .lead_err (lead_err)
    );

    typedef struct {int din; int lead;} exp_t;
    exp_t sb[$];

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask

    function automatic int exp_din(input logic [15:0] w);
        logic [11:0] d;
        d = w[11:0];
`ifdef ADC_OFFSET_BIN_EN
        d[11] = ~d[11];
`endif
        return d[11] ? int'(d) - 4096 : int'(d);
    endfunction

    logic [15:0] words [7] = '{16'h0800, 16'h07FF, 16'h0000, 16'h0FFF, 16'h5ABC, 16'h0ABC, 16'h0123};
    int fi = 0;
    logic [15:0] cur_word = '0;
    int idx = 0;

    // ADC: MSB presented on the first SCLK fall, next bit on each following fall.
    always @(negedge adc_sclk or negedge adc_cs_n)
        if (adc_sclk) idx = 0;
        else if (!adc_cs_n && idx < 16) begin
            adc_sdo = cur_word[15 - idx];
            idx++;
        end

    logic cs_prev = 1'b1;
    logic sclk_prev = 1'b1;
    int nrise = 0;
    int cs_fall_cyc = 0;
    int last_pls_cyc = 0;
    int npls = 0;
    bit prev_valid = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            sb.delete();
            prev_valid = 1'b0;
            nrise = 0;
        end else begin
            if (!adc_cs_n && !sclk_prev && adc_sclk) nrise++;
            if (cs_prev && !adc_cs_n) begin
                chk("sclk_at_cs_fall", int'(adc_sclk), 1);
                nrise = 0;
                cs_fall_cyc = cyc;
                cur_word = words[fi];
                if (fi < 6) fi++;
                e.din = exp_din(cur_word);
                e.lead = int'(|cur_word[15:12]);
                sb.push_back(e);
            end
            if (!cs_prev && adc_cs_n) begin
                chk("sclk_at_cs_rise", int'(adc_sclk), 1);
                chk("sclk_rises", nrise, 16);
                chk("cs_rise_with_pls", int'(pls20k), 1);
            end
            if (lead_err && !pls20k) chk("lead_without_pls", 0, 1);
            if (pls20k) begin
                npls++;
                if (sb.size() == 0) chk("sb_underflow", 0, 1);
                else begin
                    e = sb.pop_front();
                    chk("din", int'(din), e.din);
                    chk("lead_err", int'(lead_err), e.lead);
                    chk("pls_latency", cyc - cs_fall_cyc, 136);
                end
                if (prev_valid) chk("pls_period", cyc - last_pls_cyc, 2500);
                prev_valid = 1'b1;
                last_pls_cyc = cyc;
            end
        end
        cs_prev = adc_cs_n;
        sclk_prev = adc_sclk;
    end

    task automatic wait_pls(input int budget);
        int n0;
        n0 = npls;
        for (int i = 0; i < budget && npls == n0; i++) @(posedge clk);
        if (npls == n0) chk("pls_timeout", 0, 1);
    endtask

    int rel;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs_n", int'(adc_cs_n), 1);
        chk("rst_sclk", int'(adc_sclk), 1);
        chk("rst_din", int'(din), 0);
        chk("rst_pls", int'(pls20k), 0);
        chk("rst_lead", int'(lead_err), 0);
        #6 rst = 1'b1;
        rel = cyc;
        wait_pls(3000);
        chk("first_pls_time", last_pls_cyc - rel, 2636);
        repeat (4) wait_pls(2600);
        for (int i = 0; i < 3000 && adc_cs_n; i++) @(negedge clk);
        if (adc_cs_n) chk("cs_timeout", 0, 1);
        repeat (62) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("abort_cs_n", int'(adc_cs_n), 1);
        chk("abort_sclk", int'(adc_sclk), 1);
        chk("abort_din", int'(din), 0);
        chk("abort_pls", int'(pls20k), 0);
        @(posedge clk);
        #7 rst = 1'b1;
        rel = cyc;
        wait_pls(3000);
        chk("post_rst_pls_time", last_pls_cyc - rel, 2636);
        repeat (5) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
